// File: rtl/fulladd_checker.sv
// ----------------------------------------------------------------------------
// fulladd_checker
//
// Response monitor for a full-adder datapath. It accepts one applied operand
// vector {x, y, cin} at a time and waits SETTLE cycles for the adder to settle.
// It then samples the adder's {cout, f} and compares that against a golden
// sum computed here. It counts vectors and mismatches. After NVEC vectors it
// raises done, and raises pass when no vector failed.
//
// Parameters:
//   WIDTH   adder operand width in bits (1..16)
//   NVEC    vectors per run (1..255)
//   SETTLE  cycles between vector acceptance and result sampling (1..15)
//
// Ports:
//   clk        clock, rising edge
//   rst        asynchronous active-high reset
//   start      one-cycle pulse: clear counters and arm a run
//   vec_valid  applied x/y/cin vector is valid this cycle
//   vec_ready  checker can accept a vector
//   x, y, cin  operands applied to the adder
//   f, cout    adder sum and carry-out under check
//   mismatch   one-cycle pulse per failing compare
//   vec_cnt    vectors checked in this run
//   err_cnt    mismatches in this run, saturating at 255
//   done       run complete (level)
//   pass       run complete with err_cnt == 0 (level)
//   proto_err  sticky: vec_valid seen while vec_ready was low
//   fail_idx   vec_cnt value before the first failing vector was counted
//   fail_exp   expected {cout,f} of the first failure
//   fail_obs   observed {cout,f} of the first failure
//
// Build option: when FULLADD_CHECKER_FAILCAP_EN is defined, the first-failure
// capture registers are built. When it is undefined, fail_idx, fail_exp and
// fail_obs are tied to zero.
// ----------------------------------------------------------------------------
module fulladd_checker #(
    parameter int WIDTH  = 1,
    parameter int NVEC   = 8,
    parameter int SETTLE = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             vec_valid,
    output logic             vec_ready,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic             cin,
    input  logic [WIDTH-1:0] f,
    input  logic             cout,
    output logic             mismatch,
    output logic [7:0]       vec_cnt,
    output logic [7:0]       err_cnt,
    output logic             done,
    output logic             pass,
    output logic             proto_err,
    output logic [7:0]       fail_idx,
    output logic [WIDTH:0]   fail_exp,
    output logic [WIDTH:0]   fail_obs
);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_ARMED,
        ST_SETTLE,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t           state;
    state_t           state_nxt;
    logic [3:0]       settle_cnt;
    logic [WIDTH-1:0] x_l;
    logic [WIDTH-1:0] y_l;
    logic             cin_l;
    logic [WIDTH:0]   exp_sum;
    logic [WIDTH:0]   obs_sum;
    logic             miss;
    logic             clear;
    logic             accept;
    logic             checking;
    logic             last_vec;

    // The golden sum is computed at WIDTH+1 bits, so the carry out of the
    // top bit is kept and lines up with the observed cout.
    assign exp_sum  = {1'b0, x_l} + {1'b0, y_l} + {{WIDTH{1'b0}}, cin_l};
    assign obs_sum  = {cout, f};
    assign miss     = (exp_sum != obs_sum);

    // start is honoured only outside SETTLE/CHECK, so a vector already in
    // flight always completes. In ARMED, start takes priority over a
    // simultaneous vec_valid.
    assign clear    = start && (state == ST_IDLE || state == ST_ARMED ||
                                state == ST_DONE);
    assign accept   = (state == ST_ARMED) && vec_valid && !start;
    assign checking = (state == ST_CHECK);
    assign last_vec = ((vec_cnt + 8'd1) == 8'(NVEC));

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state is written with non-blocking assignments, so
    // every flop samples values from before the edge, regardless of block order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: the default assignment at the top keeps every path driven, so no
    // latch is inferred when a case arm leaves state_nxt unassigned.
    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:   if (start) state_nxt = ST_ARMED;
            ST_ARMED:  if (start)          state_nxt = ST_ARMED;
                       else if (vec_valid) state_nxt = ST_SETTLE;
            ST_SETTLE: if (settle_cnt == 4'd0) state_nxt = ST_CHECK;
            ST_CHECK:  state_nxt = last_vec ? ST_DONE : ST_ARMED;
            ST_DONE:   if (start) state_nxt = ST_ARMED;
            default:   state_nxt = ST_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        vec_ready = (state == ST_ARMED);
        done      = (state == ST_DONE);
        pass      = (state == ST_DONE) && (err_cnt == 8'd0);
    end

    // ------------------------------------------------------------------
    // Datapath: operand latches, settle timer, counters, flags
    // ------------------------------------------------------------------
    // NOTE: the operand latches are reset along with the control state, so a
    // post-reset compare can never act on X operands.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            x_l        <= '0;
            y_l        <= '0;
            cin_l      <= 1'b0;
            settle_cnt <= 4'd0;
            vec_cnt    <= 8'd0;
            err_cnt    <= 8'd0;
            mismatch   <= 1'b0;
            proto_err  <= 1'b0;
        end else begin
            mismatch <= checking && miss;

            if (accept) begin
                x_l        <= x;
                y_l        <= y;
                cin_l      <= cin;
                settle_cnt <= 4'(SETTLE - 1);
            end else if (state == ST_SETTLE && settle_cnt != 4'd0) begin
                settle_cnt <= settle_cnt - 4'd1;
            end

            if (clear) begin
                vec_cnt <= 8'd0;
                err_cnt <= 8'd0;
            end else if (checking) begin
                vec_cnt <= vec_cnt + 8'd1;
                if (miss && err_cnt != 8'hFF) err_cnt <= err_cnt + 8'd1;
            end

            // A vector offered while the checker is not ready is dropped
            // and flagged until the next start.
            if (clear)                       proto_err <= 1'b0;
            else if (vec_valid && !vec_ready) proto_err <= 1'b1;
        end
    end

    // ------------------------------------------------------------------
    // First-failure capture
    // ------------------------------------------------------------------
`ifdef FULLADD_CHECKER_FAILCAP_EN
    logic [7:0]     fail_idx_q;
    logic [WIDTH:0] fail_exp_q;
    logic [WIDTH:0] fail_obs_q;

    // err_cnt is still zero at the compare edge of the run's first failure.
    // Saturation never brings it back to zero, so later failures cannot
    // overwrite the capture.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fail_idx_q <= 8'd0;
            fail_exp_q <= '0;
            fail_obs_q <= '0;
        end else if (clear) begin
            fail_idx_q <= 8'd0;
            fail_exp_q <= '0;
            fail_obs_q <= '0;
        end else if (checking && miss && err_cnt == 8'd0) begin
            fail_idx_q <= vec_cnt;
            fail_exp_q <= exp_sum;
            fail_obs_q <= obs_sum;
        end
    end

    assign fail_idx = fail_idx_q;
    assign fail_exp = fail_exp_q;
    assign fail_obs = fail_obs_q;
`else
    assign fail_idx = 8'd0;
    assign fail_exp = '0;
    assign fail_obs = '0;
`endif

endmodule

// File: tb/tb_fulladd_checker.sv
// ----------------------------------------------------------------------------
// tb_fulladd_checker
//
// Directed bench for fulladd_checker. It uses two instances:
//   u_dut1: WIDTH=1, NVEC=8, SETTLE=2, driven by a behavioural full adder
//           whose cout can be forced to 0.
//   u_dut4: WIDTH=4, NVEC=2, SETTLE=1, driven by a 4-bit adder whose f can be
//           forced to 0.
// ----------------------------------------------------------------------------
module tb_fulladd_checker;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst;

    // ---------------- WIDTH=1 instance ----------------
    logic       start1, valid1, x1, y1, cin1, f1, cout1, stuck1;
    logic       ready1, mm1, done1, pass1, perr1;
    logic [7:0] vcnt1, ecnt1, fidx1;
    logic [1:0] fexp1, fobs1;
    logic [1:0] sum1;

    assign sum1  = {1'b0, x1} + {1'b0, y1} + {1'b0, cin1};
    assign f1    = sum1[0];
    assign cout1 = stuck1 ? 1'b0 : sum1[1];

    fulladd_checker #(.WIDTH(1), .NVEC(8), .SETTLE(2)) u_dut1 (
        .clk(clk), .rst(rst), .start(start1), .vec_valid(valid1),
        .vec_ready(ready1), .x(x1), .y(y1), .cin(cin1), .f(f1), .cout(cout1),
        .mismatch(mm1), .vec_cnt(vcnt1), .err_cnt(ecnt1), .done(done1),
        .pass(pass1), .proto_err(perr1), .fail_idx(fidx1),
        .fail_exp(fexp1), .fail_obs(fobs1)
    );

    // ---------------- WIDTH=4 instance ----------------
    logic       start4, valid4, cin4, cout4, zero4;
    logic [3:0] x4, y4, f4;
    logic       ready4, mm4, done4, pass4, perr4;
    logic [7:0] vcnt4, ecnt4, fidx4;
    logic [4:0] fexp4, fobs4;
    logic [4:0] sum4;

    assign sum4  = {1'b0, x4} + {1'b0, y4} + {4'd0, cin4};
    assign f4    = zero4 ? 4'h0 : sum4[3:0];
    assign cout4 = sum4[4];

    fulladd_checker #(.WIDTH(4), .NVEC(2), .SETTLE(1)) u_dut4 (
        .clk(clk), .rst(rst), .start(start4), .vec_valid(valid4),
        .vec_ready(ready4), .x(x4), .y(y4), .cin(cin4), .f(f4), .cout(cout4),
        .mismatch(mm4), .vec_cnt(vcnt4), .err_cnt(ecnt4), .done(done4),
        .pass(pass4), .proto_err(perr4), .fail_idx(fidx4),
        .fail_exp(fexp4), .fail_obs(fobs4)
    );

    int tests_run    = 0;
    int tests_failed = 0;
    int mm_cycles    = 0;   // cycles in which u_dut1 mismatch was seen high
    int rdy_low      = 0;   // u_dut1 busy cycles seen while a vector was in flight

    // Advance one clock and sample 1 ns after the rising edge.
    task automatic tick;
        @(posedge clk);
        #1;
        if (mm1) mm_cycles++;
    endtask

    task automatic pulse_start1;
        start1 = 1'b1; tick; start1 = 1'b0;
    endtask

    // Apply one {x,y,cin} vector to u_dut1. The task returns one cycle after
    // the CHECK edge, which is when the counters and mismatch are valid.
    task automatic apply1(input logic [2:0] v);
        int n;
        n = 0;
        while (!ready1 && n < 20) begin tick; n++; end
        if (!ready1) begin
            tests_run++; tests_failed++;
            $display("FAIL apply1_ready_timeout: vec_ready=%0b required 1", ready1);
        end
        {x1, y1, cin1} = v;
        valid1 = 1'b1;
        tick;                       // acceptance edge
        valid1 = 1'b0;
        if (!ready1) rdy_low++;
        tick;
        if (!ready1) rdy_low++;
        tick;                       // now in CHECK
        if (!ready1) rdy_low++;
        tick;                       // CHECK edge: result visible
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) tick;
        tests_run++;
        if ({ready1, mm1, done1, pass1, perr1} !== 5'b0) begin
            tests_failed++;
            $display("FAIL reset_flags: ready/mm/done/pass/perr=%b required 00000",
                     {ready1, mm1, done1, pass1, perr1});
        end
        tests_run++;
        if ({vcnt1, ecnt1} !== 16'h0) begin
            tests_failed++;
            $display("FAIL reset_counts: vec_cnt=%0d err_cnt=%0d required 0 0", vcnt1, ecnt1);
        end
        tests_run++;
        if ({fidx1, fexp1, fobs1} !== 12'h0) begin
            tests_failed++;
            $display("FAIL reset_failcap: idx=%0d exp=%b obs=%b required 0", fidx1, fexp1, fobs1);
        end
        tests_run++;
        if ({ready4, vcnt4, ecnt4, done4} !== 18'h0) begin
            tests_failed++;
            $display("FAIL reset_dut4: ready=%b vec_cnt=%0d err_cnt=%0d done=%b required 0",
                     ready4, vcnt4, ecnt4, done4);
        end
        @(negedge clk);
        rst = 1'b0;
        tick;
        tests_run++;
        if (ready1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL idle_not_ready: vec_ready=%b required 0", ready1);
        end
    endtask

    task automatic test_exhaustive;
        pulse_start1;
        tests_run++;
        if (ready1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL exh_armed_ready: vec_ready=%b required 1", ready1);
        end
        mm_cycles = 0;
        rdy_low   = 0;
        for (int i = 0; i < 8; i++) apply1(3'(i));
        tests_run++;
        if (vcnt1 !== 8'd8 || ecnt1 !== 8'd0) begin
            tests_failed++;
            $display("FAIL exh_counts: vec_cnt=%0d err_cnt=%0d required 8 0", vcnt1, ecnt1);
        end
        tests_run++;
        if (done1 !== 1'b1 || pass1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL exh_done_pass: done=%b pass=%b required 1 1", done1, pass1);
        end
        tests_run++;
        if (mm_cycles != 0) begin
            tests_failed++;
            $display("FAIL exh_no_mismatch: mismatch cycles=%0d required 0", mm_cycles);
        end
        tests_run++;
        if (rdy_low != 24) begin
            tests_failed++;
            $display("FAIL exh_busy_cycles: vec_ready low cycles=%0d required 24", rdy_low);
        end
    endtask

    task automatic test_restart;
        pulse_start1;
        tests_run++;
        if ({done1, pass1, ready1} !== 3'b001 || vcnt1 !== 8'd0 || ecnt1 !== 8'd0) begin
            tests_failed++;
            $display("FAIL restart: done=%b pass=%b ready=%b vec_cnt=%0d err_cnt=%0d required 0 0 1 0 0",
                     done1, pass1, ready1, vcnt1, ecnt1);
        end
    endtask

    task automatic test_fault_cout;
        stuck1    = 1'b1;
        mm_cycles = 0;
        for (int i = 0; i < 8; i++) apply1(3'(i));
        stuck1 = 1'b0;
        tests_run++;
        if (ecnt1 !== 8'd4 || vcnt1 !== 8'd8) begin
            tests_failed++;
            $display("FAIL fault_counts: err_cnt=%0d vec_cnt=%0d required 4 8", ecnt1, vcnt1);
        end
        tests_run++;
        if (done1 !== 1'b1 || pass1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL fault_done_pass: done=%b pass=%b required 1 0", done1, pass1);
        end
        tests_run++;
        if (mm_cycles != 4) begin
            tests_failed++;
            $display("FAIL fault_mismatch_pulses: mismatch cycles=%0d required 4", mm_cycles);
        end
`ifdef FULLADD_CHECKER_FAILCAP_EN
        // First failure is vector {0,1,1}, index 3: exp 2'b10, obs 2'b00.
        tests_run++;
        if (fidx1 !== 8'd3 || fexp1 !== 2'b10 || fobs1 !== 2'b00) begin
            tests_failed++;
            $display("FAIL fault_failcap: idx=%0d exp=%b obs=%b required 3 10 00", fidx1, fexp1, fobs1);
        end
`else
        tests_run++;
        if (fidx1 !== 8'd0 || fexp1 !== 2'b00 || fobs1 !== 2'b00) begin
            tests_failed++;
            $display("FAIL fault_failcap_tied: idx=%0d exp=%b obs=%b required 0 00 00", fidx1, fexp1, fobs1);
        end
`endif
    endtask

    task automatic test_protocol;
        pulse_start1;               // DONE -> ARMED
        {x1, y1, cin1} = 3'b101;
        valid1 = 1'b1;
        tick;                       // accepted
        tick;                       // still valid in SETTLE: dropped, flagged
        valid1 = 1'b0;
        tick;                       // CHECK
        tick;                       // counted
        tick;
        tests_run++;
        if (perr1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL proto_flag: proto_err=%b required 1", perr1);
        end
        tests_run++;
        if (vcnt1 !== 8'd1) begin
            tests_failed++;
            $display("FAIL proto_not_counted: vec_cnt=%0d required 1", vcnt1);
        end
        pulse_start1;               // start in ARMED re-clears
        tests_run++;
        if (perr1 !== 1'b0 || vcnt1 !== 8'd0 || ready1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL proto_clear: proto_err=%b vec_cnt=%0d ready=%b required 0 0 1",
                     perr1, vcnt1, ready1);
        end
    endtask

    task automatic test_reset_midrun;
        for (int i = 0; i < 4; i++) apply1(3'(i));
        {x1, y1, cin1} = 3'b100;
        valid1 = 1'b1;
        tick;                       // vector 5 accepted
        valid1 = 1'b0;
        tick;                       // in SETTLE
        #2 rst = 1'b1;              // asynchronous, away from any edge
        #1;
        tests_run++;
        if ({ready1, mm1, done1, pass1, perr1} !== 5'b0 || vcnt1 !== 8'd0 || ecnt1 !== 8'd0) begin
            tests_failed++;
            $display("FAIL midrun_async_reset: ready=%b mm=%b done=%b pass=%b perr=%b vec_cnt=%0d err_cnt=%0d required all 0",
                     ready1, mm1, done1, pass1, perr1, vcnt1, ecnt1);
        end
        rst = 1'b0;
        tick;
        tests_run++;
        if (ready1 !== 1'b0) begin
            tests_failed++;
            $display("FAIL midrun_idle: vec_ready=%b required 0", ready1);
        end
        pulse_start1;
        for (int i = 0; i < 8; i++) apply1(3'(7 - i));
        tests_run++;
        if (vcnt1 !== 8'd8 || done1 !== 1'b1 || pass1 !== 1'b1) begin
            tests_failed++;
            $display("FAIL midrun_rerun: vec_cnt=%0d done=%b pass=%b required 8 1 1", vcnt1, done1, pass1);
        end
    endtask

    // Apply one vector to u_dut4 (SETTLE=1: accept, SETTLE, CHECK edge).
    task automatic apply4(input logic [3:0] a, input logic [3:0] b, input logic c);
        x4 = a; y4 = b; cin4 = c;
        valid4 = 1'b1;
        tick;
        valid4 = 1'b0;
        tick;
        tick;
    endtask

    task automatic test_width4_wrap;
        start4 = 1'b1; tick; start4 = 1'b0;
        apply4(4'hF, 4'h1, 1'b1);   // 15 + 1 + 1 = 5'h11
        tests_run++;
        if (mm4 !== 1'b0 || ecnt4 !== 8'd0 || vcnt4 !== 8'd1 || ready4 !== 1'b1) begin
            tests_failed++;
            $display("FAIL w4_correct: mm=%b err_cnt=%0d vec_cnt=%0d ready=%b required 0 0 1 1",
                     mm4, ecnt4, vcnt4, ready4);
        end
        zero4 = 1'b1;
        apply4(4'hF, 4'h1, 1'b1);
        tests_run++;
        if (mm4 !== 1'b1 || ecnt4 !== 8'd1) begin
            tests_failed++;
            $display("FAIL w4_fault: mm=%b err_cnt=%0d required 1 1", mm4, ecnt4);
        end
        tests_run++;
        if (done4 !== 1'b1 || pass4 !== 1'b0 || vcnt4 !== 8'd2) begin
            tests_failed++;
            $display("FAIL w4_done: done=%b pass=%b vec_cnt=%0d required 1 0 2", done4, pass4, vcnt4);
        end
`ifdef FULLADD_CHECKER_FAILCAP_EN
        tests_run++;
        if (fidx4 !== 8'd1 || fexp4 !== 5'h11 || fobs4 !== 5'h10) begin
            tests_failed++;
            $display("FAIL w4_failcap: idx=%0d exp=%h obs=%h required 1 11 10", fidx4, fexp4, fobs4);
        end
`else
        tests_run++;
        if (fidx4 !== 8'd0 || fexp4 !== 5'h00 || fobs4 !== 5'h00) begin
            tests_failed++;
            $display("FAIL w4_failcap_tied: idx=%0d exp=%h obs=%h required 0 00 00", fidx4, fexp4, fobs4);
        end
`endif
        tick;
        zero4 = 1'b0;
        tests_run++;
        if (mm4 !== 1'b0) begin
            tests_failed++;
            $display("FAIL w4_mismatch_one_cycle: mm=%b required 0", mm4);
        end
    endtask

    initial begin
        rst    = 1'b1;
        start1 = 1'b0; valid1 = 1'b0; x1 = 1'b0; y1 = 1'b0; cin1 = 1'b0; stuck1 = 1'b0;
        start4 = 1'b0; valid4 = 1'b0; x4 = 4'h0; y4 = 4'h0; cin4 = 1'b0; zero4 = 1'b0;

        test_reset;
        test_exhaustive;
        test_restart;
        test_fault_cout;
        test_protocol;
        test_reset_midrun;
        test_width4_wrap;

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

    // Guard against a hang.
    initial begin
        #200000;
        $display("FAIL watchdog: simulation time exceeded, tests_run=%0d", tests_run);
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/fulladd_checker.md
# fulladd_checker

Self-checking response monitor that sits at the output end of the full-adder datapath, opposite the stimulus driver. It accepts one applied operand vector at a time, waits a programmable settle interval, samples the adder's sum and carry-out, and compares them against a golden sum it computes internally. It counts vectors and mismatches and raises `done` and `pass` after a programmed number of vectors, so adder correctness is checked on-chip or in simulation without manual waveform inspection.

## Interface
Parameters:
- `WIDTH`, default 1: adder operand width in bits (1..16).
- `NVEC`, default 8: vectors per run (1..255); the default covers all {x,y,cin} combinations for WIDTH=1.
- `SETTLE`, default 2: cycles to wait between vector acceptance and result sampling (1..15).

Ports (one clock; reset is asynchronous and active-high):
- `clk` in 1: clock, rising edge.
- `rst` in 1: asynchronous active-high reset.
- `start` in 1: single-cycle pulse that clears counters and arms a run.
- `vec_valid` in 1: the applied x/y/cin vector is valid this cycle.
- `vec_ready` out 1: checker can accept a vector.
- `x` in WIDTH: operand applied to the adder.
- `y` in WIDTH: operand applied to the adder.
- `cin` in 1: carry-in applied to the adder.
- `f` in WIDTH: adder sum output under check.
- `cout` in 1: adder carry-out under check.
- `mismatch` out 1: one-cycle pulse when a compare fails.
- `vec_cnt` out 8: vectors checked in this run.
- `err_cnt` out 8: mismatches in this run, saturating at 255.
- `done` out 1: run complete, level.
- `pass` out 1: run complete with err_cnt==0, level.
- `proto_err` out 1: sticky; vec_valid asserted while vec_ready low.
- `fail_idx` out 8: vec_cnt value of the first failing vector.
- `fail_exp` out WIDTH+1: expected {cout,f} of the first failure.
- `fail_obs` out WIDTH+1: observed {cout,f} of the first failure.

## Operation
- States: IDLE, ARMED, SETTLE, CHECK, DONE. Reset puts the block in IDLE.
- IDLE: `start` moves to ARMED.
- On entry to ARMED from `start`, clear vec_cnt, err_cnt, done, pass, proto_err, and the fail_* registers.
- ARMED: vec_ready=1. When vec_valid=1, latch x, y and cin, load the settle counter with SETTLE-1, and go to SETTLE.
- SETTLE: count down. At 0, go to CHECK.
- CHECK: sample f and cout. Expected value is {cout,f}_exp = x_l + y_l + cin_l, computed at WIDTH+1 bits with no truncation. Compare against the observed {cout,f}.
  - vec_cnt increments.
  - On mismatch: err_cnt increments (saturating), `mismatch` pulses, and fail_* is captured only if this is the first error of the run.
  - Next state is DONE if the new vec_cnt equals NVEC, otherwise ARMED.
- DONE: done=1 and pass=(err_cnt==0). `start` re-arms the checker to ARMED with the clears listed above.
- `start` in SETTLE or CHECK is ignored. A vector in flight always completes.
- `start` in ARMED re-clears the counters and stays in ARMED.
- vec_valid with vec_ready=0 is dropped and sets proto_err. proto_err clears only on `start` or reset.
- Only x/y/cin are latched at acceptance. f/cout must be stable by the CHECK edge.

## Timing
- Reset values: vec_ready=0, mismatch=0, vec_cnt=0, err_cnt=0, done=0, pass=0, proto_err=0, fail_idx=0, fail_exp=0, fail_obs=0.
- A vector accepted at edge E0 gives SETTLE cycles in SETTLE, then one cycle in CHECK.
  - f/cout are sampled at edge E0+SETTLE+1.
  - Counters and `mismatch` are valid in the cycle after that edge.
  - vec_ready returns to 1 in the same cycle.
- Throughput is one vector per SETTLE+2 cycles.
- done/pass are asserted in the cycle after the CHECK edge of vector NVEC.
- `mismatch` is high for exactly one cycle per failing vector.
- Reset asserted mid-run returns the block to IDLE immediately and asynchronously. All outputs take their reset values and the run is lost.

## Configuration
- `FULLADD_CHECKER_FAILCAP_EN` defined: fail_idx, fail_exp and fail_obs capture the first failure as described above.
- Not defined: the capture registers are not built, and fail_idx, fail_exp and fail_obs are tied to 0. Counting, `mismatch`, `done` and `pass` are unchanged.

## Test plan
- Exhaustive pass, WIDTH=1, NVEC=8, SETTLE=2, correct adder, all 8 {x,y,cin} vectors applied → vec_cnt=8, err_cnt=0, done=1, pass=1, mismatch never pulses, vec_ready low for 3 cycles per vector.
- Fault injection with cout stuck at 0 → mismatches at {1,1,0}, {1,0,1}, {0,1,1} and {1,1,1}.
  - err_cnt=4, pass=0.
  - With the macro defined: fail_idx = index of the first of those vectors, fail_exp=2'b10, fail_obs=2'b00.
- Protocol check: hold vec_valid during SETTLE → proto_err=1 and the vector is not counted. A following `start` → proto_err=0, vec_cnt=0.
- Reset mid-run: assert rst during SETTLE of vector 5 → all outputs 0 and state IDLE. A new `start` followed by 8 vectors → vec_cnt=8.
- WIDTH=4 wrap check: x=4'hF, y=4'h1, cin=1 → expected {cout,f}=5'h11. A correct adder passes; an adder with f=4'h0 flags a mismatch.
- Restart: `start` in DONE → returns to ARMED, counters clear, done=0, pass=0.
